// File: rtl/ninjakun_shbus_arb.sv
// Shared-bus slot arbiter: NCPU CPUs take turns on one bus in fixed-length slots.
// Define SHBUS_WRGUARD_EN to mask the bus write strobe on the first and last phase of each slot.
module ninjakun_shbus_arb #(
  parameter  int NCPU     = 2,
  parameter  int SLOT_LEN = 4,
  parameter  int AW       = 16,
  parameter  int DW       = 8,
  localparam int SW       = (NCPU == 2) ? 1 : 2
) (
  input  logic               SHCLK,
  input  logic               RESET_N,
  input  logic [NCPU-1:0]    CPEN,
  input  logic               PAUSE,
  input  logic [NCPU*AW-1:0] CPAD,
  input  logic [NCPU*DW-1:0] CPOD,
  input  logic [NCPU-1:0]    CPRD,
  input  logic [NCPU-1:0]    CPWR,
  output logic [NCPU-1:0]    CPCL,
  output logic [NCPU*DW-1:0] CPID,
  output logic [AW-1:0]      CPADR,
  output logic [DW-1:0]      CPODT,
  output logic               CPRED,
  output logic               CPWRT,
  output logic [SW-1:0]      CPSEL,
  input  logic [DW-1:0]      CPIDT
);

  localparam int PW = $clog2(SLOT_LEN);
  localparam logic [PW-1:0] PH_LAST = PW'(SLOT_LEN - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(SLOT_LEN / 2);

  logic [PW-1:0]   ph;
  logic [PW-1:0]   ph_nxt;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   sel_nxt;
  logic [SW-1:0]   sel_adv;
  logic            run;
  logic            slot_on;
  logic            slot_on_nxt;
  logic            slot_start;
  logic            en_nxt;
  logic            wr_raw;
  logic            wr_ok;
  logic [NCPU-1:0] cpcl_nxt;
  logic [DW-1:0]   dt [NCPU];

  // Next enabled owner above the current one; the search wraps back to the
  // current owner itself, and with no CPU enabled the owner stays put.
  always_comb begin
    logic found;
    int   cand;
    sel_adv = sel;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NCPU; k++) begin
      cand = (int'(sel) + k) % NCPU;
      if (!found && CPEN[cand]) begin
        sel_adv = SW'(cand);
        found   = 1'b1;
      end
    end
  end

  // run is low only for the first edge after reset, which opens slot 0 at PH=0.
  always_comb begin
    slot_start = !run || (ph == PH_LAST);
    if (!run) begin
      ph_nxt  = '0;
      sel_nxt = sel;
    end else if (ph == PH_LAST) begin
      ph_nxt  = '0;
      sel_nxt = sel_adv;
    end else begin
      ph_nxt  = ph + PW'(1);
      sel_nxt = sel;
    end
    en_nxt = 1'b0;
    for (int i = 0; i < NCPU; i++) begin
      if (int'(sel_nxt) == i) en_nxt = CPEN[i];
    end
    // Pulse eligibility is frozen at slot start so a mid-slot CPEN drop cannot cut it short.
    slot_on_nxt = slot_start ? (en_nxt && !PAUSE) : slot_on;
    cpcl_nxt = '0;
    for (int i = 0; i < NCPU; i++) begin
      cpcl_nxt[i] = slot_on_nxt && (ph_nxt < PH_HALF) && (int'(sel_nxt) == i);
    end
  end

  always_ff @(posedge SHCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      run     <= 1'b0;
      ph      <= '0;
      sel     <= '0;
      slot_on <= 1'b0;
      CPCL    <= '0;
      for (int i = 0; i < NCPU; i++) dt[i] <= '1;
    end else begin
      run     <= 1'b1;
      ph      <= ph_nxt;
      sel     <= sel_nxt;
      slot_on <= slot_on_nxt;
      CPCL    <= cpcl_nxt;
      if (run && (ph == PH_LAST)) begin
        for (int i = 0; i < NCPU; i++) begin
          if (int'(sel) == i) dt[i] <= CPIDT;
        end
      end
    end
  end

  always_comb begin
    CPADR  = '0;
    CPODT  = '0;
    CPRED  = 1'b0;
    wr_raw = 1'b0;
    for (int i = 0; i < NCPU; i++) begin
      if (int'(sel) == i) begin
        CPADR  = CPAD[i*AW +: AW];
        CPODT  = CPOD[i*DW +: DW];
        CPRED  = CPRD[i];
        wr_raw = CPWR[i];
      end
    end
  end

`ifdef SHBUS_WRGUARD_EN
  assign wr_ok = (ph != '0) && (ph != PH_LAST);
`else
  assign wr_ok = 1'b1;
`endif

  assign CPWRT = wr_raw & wr_ok;
  assign CPSEL = sel;

  // The current owner sees the live bus; everyone else sees what it last latched.
  always_comb begin
    CPID = '0;
    for (int i = 0; i < NCPU; i++) begin
      CPID[i*DW +: DW] = (int'(sel) == i) ? CPIDT : dt[i];
    end
  end

endmodule

// File: tb/tb_ninjakun_shbus_arb.sv
// Self-checking bench for ninjakun_shbus_arb: a 2-CPU and a 3-CPU instance against a slot-level model.
// Expected write-strobe masking follows SHBUS_WRGUARD_EN.
module tb_ninjakun_shbus_arb;

  localparam int SL = 4;

  logic        SHCLK;
  logic        RESET_N;

  logic [1:0]  en2, rd2, wr2, cl2;
  logic        pause2, red2, wrt2;
  logic [31:0] ad2;
  logic [15:0] od2, id2, adr2;
  logic [7:0]  idt2, odt2;
  logic [0:0]  sel2;

  logic [2:0]  en3, rd3, wr3, cl3;
  logic        pause3, red3, wrt3;
  logic [47:0] ad3;
  logic [23:0] od3, id3;
  logic [15:0] adr3;
  logic [7:0]  idt3, odt3;
  logic [1:0]  sel3;

  int n_cmp = 0;
  int n_err = 0;

  // Model state per instance (0: 2-CPU, 1: 3-CPU).
  int         m_n [2] = '{2, 3};
  bit         m_run [2];
  int         m_ph [2];
  int         m_sel [2];
  bit         m_gate [2];
  logic [7:0] m_dt [2][4];

  ninjakun_shbus_arb #(.NCPU(2), .SLOT_LEN(SL), .AW(16), .DW(8)) dut2 (
    .SHCLK(SHCLK), .RESET_N(RESET_N), .CPEN(en2), .PAUSE(pause2), .CPAD(ad2),
    .CPOD(od2), .CPRD(rd2), .CPWR(wr2), .CPCL(cl2), .CPID(id2), .CPADR(adr2),
    .CPODT(odt2), .CPRED(red2), .CPWRT(wrt2), .CPSEL(sel2), .CPIDT(idt2)
  );

  ninjakun_shbus_arb #(.NCPU(3), .SLOT_LEN(SL), .AW(16), .DW(8)) dut3 (
    .SHCLK(SHCLK), .RESET_N(RESET_N), .CPEN(en3), .PAUSE(pause3), .CPAD(ad3),
    .CPOD(od3), .CPRD(rd3), .CPWR(wr3), .CPCL(cl3), .CPID(id3), .CPADR(adr3),
    .CPODT(odt3), .CPRED(red3), .CPWRT(wrt3), .CPSEL(sel3), .CPIDT(idt3)
  );

  initial SHCLK = 1'b0;
  always #5 SHCLK = ~SHCLK;

  function automatic void model_reset(int k);
    m_run[k]  = 1'b0;
    m_ph[k]   = 0;
    m_sel[k]  = 0;
    m_gate[k] = 1'b0;
    for (int i = 0; i < 4; i++) m_dt[k][i] = 8'hFF;
  endfunction

  // One clock edge of the slot rules: phase count, owner rotation, latch load, pulse gating.
  function automatic void model_edge(int k, logic [3:0] en, logic pause, logic [7:0] idt);
    bit start;
    bit found;
    int nsel;
    start = 1'b0;
    found = 1'b0;
    nsel  = m_sel[k];
    if (!m_run[k]) begin
      m_run[k] = 1'b1;
      m_ph[k]  = 0;
      start    = 1'b1;
    end else if (m_ph[k] == SL - 1) begin
      m_dt[k][m_sel[k]] = idt;
      m_ph[k] = 0;
      start   = 1'b1;
      for (int s = 1; s <= m_n[k]; s++) begin
        if (!found && en[(m_sel[k] + s) % m_n[k]]) begin
          nsel  = (m_sel[k] + s) % m_n[k];
          found = 1'b1;
        end
      end
    end else begin
      m_ph[k] = m_ph[k] + 1;
    end
    m_sel[k] = nsel;
    if (start) m_gate[k] = en[nsel] && !pause;
  endfunction

  function automatic logic [3:0] exp_cl(int k);
    if (m_gate[k] && m_ph[k] < SL / 2) return 4'(1) << m_sel[k];
    return 4'd0;
  endfunction

  function automatic logic exp_wrt(int k, logic w);
`ifdef SHBUS_WRGUARD_EN
    return w && (m_ph[k] != 0) && (m_ph[k] != SL - 1);
`else
    return w && (k >= 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SHCLK);
    if (RESET_N) begin
      model_edge(0, {2'b00, en2}, pause2, idt2);
      model_edge(1, {1'b0, en3}, pause3, idt3);
    end
    #2;
  endtask

  task automatic applyStimulus();
    ad2 = $urandom;
    od2 = 16'($urandom);
    rd2 = 2'($urandom);
    wr2 = 2'($urandom);
    idt2 = 8'($urandom);
    ad3[31:0] = $urandom;
    ad3[47:32] = 16'($urandom);
    od3 = 24'($urandom);
    rd3 = 3'($urandom);
    wr3 = 3'($urandom);
    idt3 = 8'($urandom);
  endtask

  task automatic checkOutput();
    chk("sel2", 32'(sel2), 32'(m_sel[0]));
    chk("cl2", 32'(cl2), 32'(exp_cl(0)));
    chk("adr2", 32'(adr2), 32'(ad2[m_sel[0]*16 +: 16]));
    chk("odt2", 32'(odt2), 32'(od2[m_sel[0]*8 +: 8]));
    chk("red2", 32'(red2), 32'(rd2[m_sel[0]]));
    chk("wrt2", 32'(wrt2), 32'(exp_wrt(0, wr2[m_sel[0]])));
    for (int i = 0; i < 2; i++)
      chk("id2", 32'(id2[i*8 +: 8]), 32'((m_sel[0] == i) ? idt2 : m_dt[0][i]));
    chk("sel3", 32'(sel3), 32'(m_sel[1]));
    chk("cl3", 32'(cl3), 32'(exp_cl(1)));
    chk("adr3", 32'(adr3), 32'(ad3[m_sel[1]*16 +: 16]));
    chk("odt3", 32'(odt3), 32'(od3[m_sel[1]*8 +: 8]));
    chk("red3", 32'(red3), 32'(rd3[m_sel[1]]));
    chk("wrt3", 32'(wrt3), 32'(exp_wrt(1, wr3[m_sel[1]])));
    for (int i = 0; i < 3; i++)
      chk("id3", 32'(id3[i*8 +: 8]), 32'((m_sel[1] == i) ? idt3 : m_dt[1][i]));
  endtask

  initial begin
    int  exp_sel [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int  exp_c [8]   = '{1, 1, 0, 0, 2, 2, 0, 0};
`ifdef SHBUS_WRGUARD_EN
    int  exp_w [4]   = '{0, 1, 1, 0};
`else
    int  exp_w [4]   = '{1, 1, 1, 1};
`endif
    bit  loaded;
    bit  armed;
    bit  in_paused;
    bit  hit;

    RESET_N = 1'b0;
    en2 = 2'b11;
    en3 = 3'b101;
    pause2 = 1'b0;
    pause3 = 1'b0;
    applyStimulus();
    model_reset(0);
    model_reset(1);

    // Reset state
    tick();
    tick();
    #1;
    checkOutput();
    chk("rst_cl2", 32'(cl2), 32'd0);
    chk("rst_id2_1", 32'(id2[15:8]), 32'hFF);
    RESET_N = 1'b1;

    // Two frames of alternating slots; 3-CPU instance skips the disabled CPU 1
    for (int c = 0; c < 16; c++) begin
      tick();
      applyStimulus();
      #1;
      checkOutput();
      chk("frame_sel", 32'(sel2), 32'(exp_sel[c % 8]));
      chk("frame_cl", 32'(cl2), 32'(exp_c[c % 8]));
      chk("skip_sel3", 32'(sel3), ((c / 4) % 2 == 1) ? 32'd2 : 32'd0);
      chk("skip_cl3_1", 32'(cl3[1]), 32'd0);
    end

    // CPU1 read returned through its latch during the following CPU0 slot
    loaded = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      applyStimulus();
      rd2 = 2'b10;
      if (m_sel[0] == 1 && m_ph[0] == SL - 1) begin
        idt2 = 8'h5A;
        loaded = 1'b1;
      end else begin
        idt2 = 8'h00;
      end
      #1;
      checkOutput();
      if (loaded && m_sel[0] == 0) chk("rd_latch", 32'(id2[15:8]), 32'h5A);
    end

    // PAUSE at the end of slot 0 silences slot 1 only
    armed = 1'b0;
    in_paused = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      applyStimulus();
      if (m_ph[0] == 0) begin
        in_paused = armed;
        armed = 1'b0;
      end
      pause2 = (m_sel[0] == 0 && m_ph[0] == SL - 1 && c < 8);
      if (pause2) armed = 1'b1;
      #1;
      checkOutput();
      if (in_paused) begin
        chk("pause_cl", 32'(cl2), 32'd0);
        chk("pause_sel", 32'(sel2), 32'd1);
        chk("pause_adr", 32'(adr2), 32'(ad2[31:16]));
      end
    end
    pause2 = 1'b0;

    // Write strobe masking across the phases of a slot
    for (int c = 0; c < 8; c++) begin
      tick();
      applyStimulus();
      wr2 = 2'b11;
      #1;
      checkOutput();
      chk("wrt_ph", 32'(wrt2), 32'(exp_w[m_ph[0]]));
    end

    // Reset dropped at PH=2 of slot 1
    hit = 1'b0;
    for (int c = 0; c < 16 && !hit; c++) begin
      tick();
      applyStimulus();
      hit = (m_sel[0] == 1 && m_ph[0] == 2);
    end
    chk("reach_ph2_slot1", 32'(hit), 32'd1);
    RESET_N = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    chk("rst_mid_cl", 32'(cl2), 32'd0);
    chk("rst_mid_sel", 32'(sel2), 32'd0);
    chk("rst_mid_id1", 32'(id2[15:8]), 32'hFF);
    checkOutput();
    tick();
    #1;
    checkOutput();
    RESET_N = 1'b1;
    tick();
    applyStimulus();
    #1;
    checkOutput();
    chk("restart_sel", 32'(sel2), 32'd0);
    chk("restart_cl", 32'(cl2), 32'd1);

    // Randomized enables, pauses and traffic
    for (int c = 0; c < 400; c++) begin
      tick();
      applyStimulus();
      en2 = 2'($urandom);
      en3 = 3'($urandom);
      pause2 = ($urandom_range(0, 3) == 0);
      pause3 = ($urandom_range(0, 3) == 0);
      #1;
      checkOutput();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
